// File: rtl/conv_window_ctrl_if.sv
// Pixel handshake and window-result bus between the stream endpoints and conv_window_ctrl.
interface conv_window_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             pix_valid;
  logic             pix_ready;
  logic             out_valid;
  logic [CNT_W-1:0] out_col;
  logic [CNT_W-1:0] out_row;
  logic             out_row_last;
  logic             frame_done;

  modport master (
    output pix_valid,
    input  pix_ready, out_valid, out_col, out_row, out_row_last, frame_done
  );

  modport slave (
    input  pix_valid,
    output pix_ready, out_valid, out_col, out_row, out_row_last, frame_done
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Window-valid controller: tracks input pixel position, flags stride-aligned KxK windows and
// re-times them by PIPE_LAT. A start spends one extra CALC cycle computing OW/OH before RUN.
module conv_window_ctrl #(
  parameter int CNT_W       = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE_W    = 4,
  parameter int PIPE_LAT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_img_w,
  input  logic [CNT_W-1:0]    cfg_img_h,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic                cfg_continuous,
  input  logic                stop,
  conv_window_ctrl_if.slave   pix,
  output logic                busy,
  output logic                cfg_err,
  output logic [15:0]         frame_cnt
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [CNT_W-1:0]    K_C       = CNT_W'(KERNEL_SIZE);
  localparam logic [CNT_W-1:0]    K_M1      = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [PIPE_LAT-1:0] PEND_MASK = PIPE_LAT'((64'd1 << (PIPE_LAT - 1)) - 64'd1);

  logic [1:0]          state_r, state_nx_s;
  logic [CNT_W-1:0]    w_r, h_r, ow_r, oh_r;
  logic [STRIDE_W-1:0] s_r;
  logic                cont_r, stop_seen_r, cfg_err_r;
  logic [CNT_W-1:0]    col_r, row_r, ocol_r, orow_r;
  logic [STRIDE_W-1:0] cph_r, rph_r;
  logic [PIPE_LAT-1:0] pipe_r;
  logic [15:0]         frame_cnt_r;

  logic accept_s, win_s, col_last_s, row_last_s, pix_last_s;
  logic out_valid_s, ocol_last_s, orow_last_s, done_s;
  logic stop_any_s, pend_s, bad_cfg_s, flush_s;
  logic [STRIDE_W-1:0] s_m1_s;

  assign accept_s    = pix.pix_valid & (state_r == ST_RUN);
  assign col_last_s  = (col_r == w_r - CNT_W'(1));
  assign row_last_s  = (row_r == h_r - CNT_W'(1));
  assign pix_last_s  = accept_s & col_last_s & row_last_s;
  assign s_m1_s      = s_r - STRIDE_W'(1);
  assign win_s       = accept_s & (col_r >= K_M1) & (row_r >= K_M1) &
                       (cph_r == '0) & (rph_r == '0);
  assign out_valid_s = pipe_r[PIPE_LAT-1];
  assign ocol_last_s = (ocol_r == ow_r - CNT_W'(1));
  assign orow_last_s = (orow_r == oh_r - CNT_W'(1));
  assign done_s      = out_valid_s & ocol_last_s & orow_last_s;
  assign stop_any_s  = stop_seen_r | stop;
  // Later flags still in the pipe belong to a newer frame, so DRAIN must not end yet.
  assign pend_s      = |(pipe_r & PEND_MASK);
  assign bad_cfg_s   = (cfg_img_w < K_C) | (cfg_img_h < K_C) | (cfg_stride == '0);
  assign flush_s     = (state_r == ST_RUN) & done_s & stop_any_s;

  // Next-state selection.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !bad_cfg_s) state_nx_s = ST_CALC;
        else                     state_nx_s = ST_IDLE;
      end
      ST_CALC: state_nx_s = ST_RUN;
      ST_RUN: begin
        if (flush_s)                                     state_nx_s = ST_IDLE;
        else if (pix_last_s && !(cont_r && !stop_any_s)) state_nx_s = ST_DRAIN;
        else                                             state_nx_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (done_s && !pend_s) state_nx_s = ST_IDLE;
        else                   state_nx_s = ST_DRAIN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, configuration latch, output-size compute and sticky stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      w_r         <= '0;
      h_r         <= '0;
      s_r         <= '0;
      cont_r      <= 1'b0;
      ow_r        <= '0;
      oh_r        <= '0;
      stop_seen_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cfg_err_r <= (state_r == ST_IDLE) & start & bad_cfg_s;
      if (state_r == ST_IDLE && start) begin
        w_r    <= cfg_img_w;
        h_r    <= cfg_img_h;
        s_r    <= cfg_stride;
        cont_r <= cfg_continuous;
      end
      if (state_r == ST_CALC) begin
        ow_r <= (w_r - K_C) / CNT_W'(s_r) + CNT_W'(1);
        oh_r <= (h_r - K_C) / CNT_W'(s_r) + CNT_W'(1);
      end
      if (state_r == ST_IDLE) stop_seen_r <= 1'b0;
      else if (stop)          stop_seen_r <= 1'b1;
    end
  end

  // Input position and stride-phase counters; phases restart where the first window fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
      cph_r <= '0;
      rph_r <= '0;
    end else if (state_r != ST_RUN || flush_s) begin
      col_r <= '0;
      row_r <= '0;
      cph_r <= '0;
      rph_r <= '0;
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= '0;
        cph_r <= '0;
        if (row_last_s) begin
          row_r <= '0;
          rph_r <= '0;
        end else begin
          row_r <= row_r + CNT_W'(1);
          rph_r <= (row_r < K_M1 || rph_r == s_m1_s) ? '0 : rph_r + STRIDE_W'(1);
        end
      end else begin
        col_r <= col_r + CNT_W'(1);
        cph_r <= (col_r < K_M1 || cph_r == s_m1_s) ? '0 : cph_r + STRIDE_W'(1);
      end
    end
  end

  // Latency pipe, output coordinates and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_r      <= '0;
      ocol_r      <= '0;
      orow_r      <= '0;
      frame_cnt_r <= '0;
    end else begin
      if (flush_s) pipe_r <= '0;
      else         pipe_r <= PIPE_LAT'({pipe_r, win_s});
      if (out_valid_s) begin
        if (ocol_last_s) begin
          ocol_r <= '0;
          if (orow_last_s) begin
            orow_r      <= '0;
            frame_cnt_r <= frame_cnt_r + 16'd1;
          end else begin
            orow_r <= orow_r + CNT_W'(1);
          end
        end else begin
          ocol_r <= ocol_r + CNT_W'(1);
        end
      end
    end
  end

  assign pix.pix_ready    = (state_r == ST_RUN);
  assign pix.out_valid    = out_valid_s;
  assign pix.out_col      = ocol_r;
  assign pix.out_row      = orow_r;
  assign pix.out_row_last = out_valid_s & ocol_last_s;
  assign pix.frame_done   = done_s;
  assign busy             = (state_r != ST_IDLE);
  assign cfg_err          = cfg_err_r;
  assign frame_cnt        = frame_cnt_r;
endmodule
